// File: rtl/servo_pkg.sv
// Shared definitions for the servo arbiter: requester indices, FSM encoding
// and the single-frame slew step used by both servo channels.
package servo_pkg;

    localparam int REQ_STOP   = 0;
    localparam int REQ_MANUAL = 1;
    localparam int REQ_LINE   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // Move cur toward tgt by at most step; never overshoots, so no wrap.
    function automatic logic [7:0] slew_step(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] step);
        logic [7:0] result;
        if (tgt > cur) begin
            result = ((tgt - cur) <= step) ? tgt : cur + step;
        end else begin
            result = ((cur - tgt) <= step) ? tgt : cur - step;
        end
        return result;
    endfunction

endpackage

// File: rtl/servo_slew.sv
// One servo channel's slew limiter: next value one step closer to target.
module servo_slew
    import servo_pkg::*;
(
    input  logic [7:0] current,
    input  logic [7:0] target,
    input  logic [7:0] step,
    output logic [7:0] next_value
);

    assign next_value = slew_step(current, target, step);

endmodule

// File: rtl/servo_arbiter.sv
// Frame-based fixed-priority arbiter for three servo command sources with
// slew limiting, emergency bypass and a request watchdog.
//
// Handshake: req[i] is a level held by requester i; the arbiter samples it
// only in the frame_tick cycle, and ack[i] pulses for the one cycle after the
// tick in which requester i's cmd_l/cmd_r were captured.
module servo_arbiter
    import servo_pkg::*;
#(
    parameter int FRAME_TICKS    = 2000,
    parameter int SLEW_STEP      = 4,
    parameter int TIMEOUT_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [7:0] cmd_l0,
    input  logic [7:0] cmd_l1,
    input  logic [7:0] cmd_l2,
    input  logic [7:0] cmd_r0,
    input  logic [7:0] cmd_r1,
    input  logic [7:0] cmd_r2,
    output logic [2:0] ack,
    output logic [2:0] grant,
    output logic       frame_tick,
    output logic [7:0] servo_l,
    output logic [7:0] servo_r,
    output logic       fault,
    output logic [1:0] fsm_state
);

    localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int IW = $clog2(TIMEOUT_FRAMES + 1);

    logic [CW-1:0] frame_cnt;
    logic [IW-1:0] idle_cnt, idle_n;
    state_t        state, state_n;
    logic [7:0]    target_l, target_r, target_l_n, target_r_n;
    logic [7:0]    slew_l, slew_r, servo_l_n, servo_r_n;
    logic [2:0]    grant_n, ack_n;
    logic          fault_n, bypass;

    assign frame_tick = (frame_cnt == CW'(FRAME_TICKS - 1));
    assign fsm_state  = state;

    always_ff @(posedge clk) begin
        if (rst || frame_tick) frame_cnt <= '0;
        else                   frame_cnt <= frame_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idle_cnt <= '0;
            target_l <= '0;
            target_r <= '0;
            grant    <= '0;
            ack      <= '0;
            fault    <= 1'b0;
            servo_l  <= '0;
            servo_r  <= '0;
        end else begin
            state    <= state_n;
            idle_cnt <= idle_n;
            target_l <= target_l_n;
            target_r <= target_r_n;
            grant    <= grant_n;
            ack      <= ack_n;
            fault    <= fault_n;
            servo_l  <= servo_l_n;
            servo_r  <= servo_r_n;
        end
    end

    always_comb begin
        state_n    = state;
        idle_n     = idle_cnt;
        target_l_n = target_l;
        target_r_n = target_r;
        grant_n    = grant;
        ack_n      = '0;
        fault_n    = fault;
        bypass     = 1'b0;
        if (frame_tick) begin
            if (req != 3'b000) begin
                grant_n = '0;
                if (req[REQ_STOP]) begin
                    grant_n[REQ_STOP] = 1'b1;
                    target_l_n        = cmd_l0;
                    target_r_n        = cmd_r0;
                    bypass            = 1'b1;
                end else if (req[REQ_MANUAL]) begin
                    grant_n[REQ_MANUAL] = 1'b1;
                    target_l_n          = cmd_l1;
                    target_r_n          = cmd_r1;
                end else begin
                    grant_n[REQ_LINE] = 1'b1;
                    target_l_n        = cmd_l2;
                    target_r_n        = cmd_r2;
                end
                ack_n   = grant_n;
                state_n = ST_RUN;
                fault_n = 1'b0;
                idle_n  = '0;
            end else begin
                grant_n = '0;
                idle_n  = (idle_cnt == IW'(TIMEOUT_FRAMES)) ? idle_cnt : idle_cnt + 1'b1;
                // Saturated idle count keeps FAULT sticky until a request arrives.
                if (idle_n == IW'(TIMEOUT_FRAMES)) begin
                    state_n    = ST_FAULT;
                    fault_n    = 1'b1;
                    target_l_n = '0;
                    target_r_n = '0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
        end
    end

    servo_slew u_slew_l (
        .current    (servo_l),
        .target     (target_l_n),
        .step       (8'(SLEW_STEP)),
        .next_value (slew_l)
    );

    servo_slew u_slew_r (
        .current    (servo_r),
        .target     (target_r_n),
        .step       (8'(SLEW_STEP)),
        .next_value (slew_r)
    );

    assign servo_l_n = !frame_tick ? servo_l : (bypass ? cmd_l0 : slew_l);
    assign servo_r_n = !frame_tick ? servo_r : (bypass ? cmd_r0 : slew_r);

endmodule

// File: tb/tb_servo_arbiter.sv
// Randomised scoreboard bench for servo_arbiter with a frame-level reference
// model (FRAME_TICKS=10, SLEW_STEP=4, TIMEOUT_FRAMES=3).
module tb_servo_arbiter;

  localparam int FT   = 10;
  localparam int SLEW = 4;
  localparam int TO   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic [7:0] cl[3];
  logic [7:0] cr[3];
  logic [2:0] ack, grant;
  logic       frame_tick, fault;
  logic [7:0] servo_l, servo_r;
  logic [1:0] fsm_state;

  logic [22:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  int m_sl, m_sr, m_tl, m_tr, m_idle;
  logic m_fault;
  logic [2:0] m_grant;

  servo_arbiter #(.FRAME_TICKS(FT), .SLEW_STEP(SLEW), .TIMEOUT_FRAMES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .cmd_l0     (cl[0]),
    .cmd_l1     (cl[1]),
    .cmd_l2     (cl[2]),
    .cmd_r0     (cr[0]),
    .cmd_r1     (cr[1]),
    .cmd_r2     (cr[2]),
    .ack        (ack),
    .grant      (grant),
    .frame_tick (frame_tick),
    .servo_l    (servo_l),
    .servo_r    (servo_r),
    .fault      (fault),
    .fsm_state  (fsm_state)
  );

  // clock / time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL time_limit: simulation did not finish within 200000 time units");
    $fatal(1, "time limit");
  end

  // reference model
  function automatic int toward(input int s, input int t);
    if (t - s > SLEW) return s + SLEW;
    if (s - t > SLEW) return s - SLEW;
    return t;
  endfunction

  task automatic model_reset();
    m_sl = 0; m_sr = 0; m_tl = 0; m_tr = 0; m_idle = 0;
    m_fault = 1'b0; m_grant = 3'b000;
  endtask

  task automatic model_tick(input logic [2:0] rq);
    int w;
    w = -1;
    for (int i = 2; i >= 0; i--) if (rq[i]) w = i;
    if (w >= 0) begin
      m_tl = int'(cl[w]); m_tr = int'(cr[w]);
      m_grant = 3'(1 << w);
      m_idle = 0; m_fault = 1'b0;
      if (w == 0) begin
        m_sl = m_tl; m_sr = m_tr;
      end else begin
        m_sl = toward(m_sl, m_tl); m_sr = toward(m_sr, m_tr);
      end
    end else begin
      m_grant = 3'b000;
      if (m_idle < TO) m_idle++;
      if (m_idle == TO) begin
        m_fault = 1'b1; m_tl = 0; m_tr = 0;
      end
      m_sl = toward(m_sl, m_tl); m_sr = toward(m_sr, m_tr);
    end
    exp_q.push_back({m_grant, m_grant, m_fault, 8'(m_sl), 8'(m_sr)});
  endtask

  // driver tasks: each frame starts at counter value 0, inputs change #1 after posedge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [2:0] rq,
                           input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                           input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                           input bit noise);
    for (int i = 0; i < FT; i++) begin
      if (i == FT - 1 || !noise) begin
        req = rq;
        cl[0] = l0; cl[1] = l1; cl[2] = l2;
        cr[0] = r0; cr[1] = r1; cr[2] = r2;
      end else begin
        req = 3'($urandom_range(0, 7));
        for (int j = 0; j < 3; j++) begin
          cl[j] = 8'($urandom_range(0, 255));
          cr[j] = 8'($urandom_range(0, 255));
        end
      end
      if (i == FT - 1) model_tick(rq);
      next_cycle();
    end
  endtask

  task automatic pulse_frame();
    for (int i = 0; i < FT; i++) begin
      req = (i >= 2 && i <= 5) ? 3'b001 : 3'b000;
      cl[0] = 8'd99; cr[0] = 8'd99;
      if (i == FT - 1) model_tick(req);
      next_cycle();
    end
  endtask

  // scoreboard monitor
  task automatic check(input string name, input int act, input int exp, input int cyc);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d after reset)", name, act, exp, cyc);
    end
  endtask

  initial begin
    int mc;
    logic [22:0] e;
    logic [2:0] last_grant;
    logic last_fault;
    logic [7:0] last_sl, last_sr;
    mc = 0;
    last_grant = 3'b000; last_fault = 1'b0; last_sl = 8'd0; last_sr = 8'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mc = 0;
        last_grant = 3'b000; last_fault = 1'b0; last_sl = 8'd0; last_sr = 8'd0;
      end else begin
        check("frame_tick", int'(frame_tick), int'(mc % FT == FT - 1), mc);
        if (mc % FT == 0 && mc > 0) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_underflow: got a frame update with no expected entry (cycle %0d)", mc);
          end else begin
            e = exp_q.pop_front();
            check("grant", int'(grant), int'(e[22:20]), mc);
            check("ack", int'(ack), int'(e[19:17]), mc);
            check("fault", int'(fault), int'(e[16]), mc);
            check("servo_l", int'(servo_l), int'(e[15:8]), mc);
            check("servo_r", int'(servo_r), int'(e[7:0]), mc);
            last_grant = e[22:20]; last_fault = e[16];
            last_sl = e[15:8]; last_sr = e[7:0];
          end
        end else begin
          check("ack_idle", int'(ack), 0, mc);
          check("grant_hold", int'(grant), int'(last_grant), mc);
          check("fault_hold", int'(fault), int'(last_fault), mc);
          check("servo_l_hold", int'(servo_l), int'(last_sl), mc);
          check("servo_r_hold", int'(servo_r), int'(last_sr), mc);
        end
        mc++;
      end
    end
  end

  // stimulus
  initial begin
    logic [7:0] a[3];
    logic [7:0] b[3];
    logic [2:0] rq;
    for (int j = 0; j < 3; j++) begin cl[j] = 8'd0; cr[j] = 8'd0; end
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // no requests: ticks at 9,19,29 and fault after the third, servos stay 0
    for (int f = 0; f < 4; f++) run_frame(3'b000, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    // line follower leaves fault and slews up to 155/137
    for (int f = 0; f < 40; f++) run_frame(3'b100, 8'd1, 8'd2, 8'd155, 8'd3, 8'd4, 8'd137, 1'b1);
    // emergency stop bypasses slew
    run_frame(3'b001, 8'd0, 8'd50, 8'd155, 8'd0, 8'd60, 8'd137, 1'b1);
    // request only mid-frame: no effect
    pulse_frame();
    // manual beats line follower
    for (int f = 0; f < 6; f++) run_frame(3'b110, 8'd7, 8'd200, 8'd30, 8'd7, 8'd60, 8'd30, 1'b1);
    // go idle into fault while servos are away from 0, then resume
    for (int f = 0; f < 5; f++) run_frame(3'b000, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
    for (int f = 0; f < 4; f++) run_frame(3'b100, 8'd0, 8'd0, 8'd90, 8'd0, 8'd0, 8'd250, 1'b1);

    // random frames
    for (int f = 0; f < 30; f++) begin
      rq = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      for (int j = 0; j < 3; j++) begin
        a[j] = 8'($urandom_range(0, 255));
        b[j] = 8'($urandom_range(0, 255));
      end
      run_frame(rq, a[0], a[1], a[2], b[0], b[1], b[2], 1'b1);
    end

    // reset in the middle of a frame, then the frame restarts from zero
    for (int i = 0; i < 5; i++) begin
      req = 3'($urandom_range(0, 7));
      next_cycle();
    end
    rst = 1'b1;
    model_reset();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    run_frame(3'b010, 8'd0, 8'd20, 8'd0, 8'd0, 8'd10, 8'd0, 1'b1);
    run_frame(3'b100, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd2, 1'b1);
    run_frame(3'b000, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);

    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/servo_arbiter.md
SERVO_ARBITER -- requirements
Module: servo_arbiter

Interface
REQ-001 Parameter FRAME_TICKS, default 2000, clk cycles per servo update frame (>=4).
REQ-002 Parameter SLEW_STEP, default 4, max per-frame change of each servo output.
REQ-003 Parameter TIMEOUT_FRAMES, default 8, consecutive request-free frames before fault.
REQ-004 clk  input  1  system clock; all logic on posedge.
REQ-005 rst  input  1  reset: synchronous, active-high.
REQ-006 req  input  3  per-requester command valid; [0]=stop/emergency, [1]=manual, [2]=line follower.
REQ-007 cmd_l0/cmd_l1/cmd_l2  input  8 each  requested left servo value per requester.
REQ-008 cmd_r0/cmd_r1/cmd_r2  input  8 each  requested right servo value per requester.
REQ-009 ack  output  3  one-cycle pulse to the requester whose command was captured.
REQ-010 grant  output  3  one-hot current owner; 3'b000 when none.
REQ-011 frame_tick  output  1  one-cycle pulse on last cycle of each frame.
REQ-012 servo_l, servo_r  output  8 each  slew-limited servo commands.
REQ-013 fault  output  1  watchdog timeout flag.

Function
REQ-014 Frame counter SHALL count 0..FRAME_TICKS-1 and wrap; frame_tick=1 exactly when counter==FRAME_TICKS-1.
REQ-015 Arbitration SHALL occur only in the frame_tick cycle; req changes mid-frame SHALL have no effect.
REQ-016 Priority SHALL be fixed: req[0] > req[1] > req[2]; lowest index asserted wins.
REQ-017 At the frame_tick edge the winner's cmd_l/cmd_r SHALL be captured into target_l/target_r, grant SHALL become winner one-hot, and ack[winner] SHALL be 1 for the following cycle only.
REQ-018 When req==0 at frame_tick, grant SHALL become 3'b000, no ack, targets unchanged.
REQ-019 At each frame_tick edge each servo output SHALL step toward the newly captured target: equal if |target-servo|<=SLEW_STEP, else servo+/-SLEW_STEP; unsigned 8-bit, no wrap.
REQ-020 Winner req[0] SHALL bypass slew: servo_l/servo_r SHALL load cmd_l0/cmd_r0 directly at that edge.
REQ-021 FSM states: IDLE (grant 0), RUN (grant nonzero), FAULT; IDLE->RUN and RUN->RUN on any req at frame_tick; RUN->IDLE on req==0 at frame_tick.
REQ-022 Idle-frame counter SHALL increment at each frame_tick with req==0 and clear at any frame_tick with req!=0; saturate at TIMEOUT_FRAMES.
REQ-023 Reaching TIMEOUT_FRAMES SHALL enter FAULT: fault=1, targets forced to 0, servos continue slewing to 0.
REQ-024 FAULT->RUN SHALL occur at the first frame_tick with req!=0; fault clears at that same edge.
REQ-025 Between frame ticks servo_l, servo_r, grant, targets SHALL hold.

Reset
REQ-026 On rst: servo_l=0, servo_r=0, grant=0, ack=0, fault=0, targets=0, frame and idle counters=0, state=IDLE.
REQ-027 rst asserted mid-frame SHALL abort the frame; first frame_tick after release occurs FRAME_TICKS cycles later.

Structure
REQ-028 Requester index constants, state encoding, and slew step function SHALL live in shared package servo_pkg.
REQ-029 One sub-module servo_slew (8-bit current, target, step -> next value) SHALL be instantiated twice.

Verification (FRAME_TICKS=10, SLEW_STEP=4, TIMEOUT_FRAMES=3)
REQ-030 Reset release, no req -> frame_tick at cycles 9,19,29; fault=1 after 3rd tick; servos stay 0.
REQ-031 req=3'b100, cmd_l2=155, cmd_r2=137 -> ack[2] pulse per frame, grant=3'b100, servo_l 0,4,8..155 (40th frame reaches 155).
REQ-032 req=3'b110 -> grant=3'b010, ack[1] only; req[2] never acked.
REQ-033 Servos at 155/137, req[0] with cmd 0/0 -> both outputs 0 at next frame_tick, no slew.
REQ-034 req toggled 1 for cycles 2..5 only (mid-frame) -> no grant, no ack.
REQ-035 In FAULT, req=3'b100 at tick -> fault=0, grant=3'b100, slew resumes from current values.
